// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush and bubble insertion.
// Define PIPE_STAGE_SKID_EN for a second (skid) entry and a registered in_ready.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       CTRL_W     = 8,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  // Encodings equal the number of held entries, so occupancy is the state itself.
`ifdef PIPE_STAGE_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;
`else
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1} state_e;
`endif

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic              push, pop;
`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              in_ready_q, in_ready_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_data_q <= RESET_DATA;
      main_ctrl_q <= '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      in_ready_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
`ifdef PIPE_STAGE_SKID_EN
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      in_ready_q  <= in_ready_d;
`endif
    end
  end

  always_comb begin
    push        = in_valid & in_ready;
    pop         = out_valid & out_ready;
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
`endif
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d     = ONE;
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
        end
      end
      ONE: begin
        if (push && pop) begin
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
        end else if (pop) begin
          state_d = EMPTY;
`ifdef PIPE_STAGE_SKID_EN
        end else if (push) begin
          state_d     = TWO;
          skid_data_d = in_data;
          skid_ctrl_d = in_ctrl;
`endif
        end
      end
`ifdef PIPE_STAGE_SKID_EN
      TWO: begin
        if (pop) begin
          state_d     = ONE;
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
        end
      end
`endif
      default: state_d = EMPTY;
    endcase
    // Flush squashes every entry and any concurrent input; payload is left untouched.
    if (flush) begin
      state_d     = EMPTY;
      main_data_d = main_data_q;
      main_ctrl_d = '0;
    end
`ifdef PIPE_STAGE_SKID_EN
    in_ready_d = (state_d != TWO);
`endif
  end

  always_comb begin
    out_valid = (state_q != EMPTY);
    out_data  = main_data_q;
    out_ctrl  = out_valid ? main_ctrl_q : '0;
    occupancy = state_q;
`ifdef PIPE_STAGE_SKID_EN
    in_ready  = in_ready_q;
`else
    in_ready  = ~reset & (out_ready | ~out_valid);
`endif
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg; honours PIPE_STAGE_SKID_EN like the design.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [7:0]  in_ctrl, out_ctrl;
  logic [1:0]  occupancy;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [39:0] expq[$];

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .RESET_DATA(32'h0)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a beat leaves the stage.
  always @(negedge clk) begin
    if (!reset) begin
      if (!out_valid) chk("bubble_ctrl", {56'd0, out_ctrl}, 64'd0);
      if (out_valid && out_ready && !flush) begin
        if (expq.size() == 0) begin
          chk("unexpected_beat", {24'd0, out_ctrl, out_data}, 64'hDEAD);
        end else begin
          chk("out_beat", {24'd0, out_ctrl, out_data}, {24'd0, expq.pop_front()});
        end
      end
    end
  end

  // One clock: record an accepted input at the negedge, return at posedge+1.
  task automatic tick(output bit acc);
    @(negedge clk);
    acc = in_valid && in_ready && !flush && !reset;
    if (acc) expq.push_back({in_ctrl, in_data});
    if (flush || reset) expq.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    bit a;
    for (int unsigned i = 0; i < n; i++) tick(a);
  endtask

  task automatic send(input logic [31:0] d, input logic [7:0] c, output int unsigned n);
    bit acc;
    in_valid = 1'b1; in_data = d; in_ctrl = c; n = 0;
    do begin
      tick(acc);
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n, sum;
    bit acc;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_ctrl = '0;
    idle(2);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_ctrl",  {56'd0, out_ctrl}, 64'd0);
    chk("rst_out_data",  {32'd0, out_data}, 64'd0);
    chk("rst_occ",       {62'd0, occupancy}, 64'd0);
    chk("rst_in_ready",  {63'd0, in_ready}, 64'd0);
    reset = 1'b0;
    idle(1);

    // T2 streaming at full rate, one cycle latency
    sum = 0;
    for (int unsigned i = 1; i <= 8; i++) begin
      send(i, 8'(i), n);
      sum += n;
      if (i == 1) begin
        #1;
        chk("t2_latency_valid", {63'd0, out_valid}, 64'd1);
        chk("t2_latency_data",  {32'd0, out_data}, 64'd1);
      end
    end
    chk("t2_rate", 64'(sum), 64'd8);
    idle(3);
    chk("t2_drained", 64'(expq.size()), 64'd0);

`ifdef PIPE_STAGE_SKID_EN
    // T3 stall into the skid entry
    send(32'hA, 8'h1A, n);
    out_ready = 1'b0;
    send(32'hB, 8'h1B, n);
    #1;
    chk("t3_occ2",      {62'd0, occupancy}, 64'd2);
    chk("t3_in_ready0", {63'd0, in_ready}, 64'd0);
    chk("t3_stall_data", {32'd0, out_data}, 64'hA);
    in_valid = 1'b1; in_data = 32'hC; in_ctrl = 8'h1C;
    tick(acc);
    chk("t3_c_held", {63'd0, acc}, 64'd0);
    chk("t3_stable_data", {32'd0, out_data}, 64'hA);
    out_ready = 1'b1;
    send(32'hC, 8'h1C, n);
    chk("t3_c_wait", 64'(n), 64'd2);
    idle(3);
    chk("t3_drained", 64'(expq.size()), 64'd0);
`endif

    // T4 flush with a concurrent input beat
    out_ready = 1'b0;
    send(32'h10, 8'h01, n);
`ifdef PIPE_STAGE_SKID_EN
    send(32'h11, 8'h02, n);
    #1;
    chk("t4_occ2", {62'd0, occupancy}, 64'd2);
`endif
    out_ready = 1'b1; flush = 1'b1;
    in_valid = 1'b1; in_data = 32'h12; in_ctrl = 8'h03;
    tick(acc);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("t4_out_valid", {63'd0, out_valid}, 64'd0);
    chk("t4_out_ctrl",  {56'd0, out_ctrl}, 64'd0);
    chk("t4_occ",       {62'd0, occupancy}, 64'd0);
    chk("t4_data_hold", {32'd0, out_data}, 64'h10);
    idle(3);
    chk("t4_no_0x12", {63'd0, out_valid}, 64'd0);

    // T5 bubble after a beat carrying all control bits
    send(32'h20, 8'hFF, n);
    #1;
    chk("t5_ctrl_ff", {56'd0, out_ctrl}, 64'hFF);
    idle(1);
    chk("t5_valid0",  {63'd0, out_valid}, 64'd0);
    chk("t5_ctrl0",   {56'd0, out_ctrl}, 64'd0);
    chk("t5_data_hold", {32'd0, out_data}, 64'h20);

`ifndef PIPE_STAGE_SKID_EN
    // T6 combinational in_ready in the single-entry build
    out_ready = 1'b0;
    send(32'h30, 8'h33, n);
    #1;
    chk("t6_in_ready0", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b1; in_data = 32'h31; in_ctrl = 8'h34;
    tick(acc);
    chk("t6_not_taken", {63'd0, acc}, 64'd0);
    chk("t6_occ1", {62'd0, occupancy}, 64'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("t6_in_ready1", {63'd0, in_ready}, 64'd1);
    idle(2);
`endif

    // T1 reset mid-stream with the stage full
    out_ready = 1'b0;
    send(32'h40, 8'h11, n);
`ifdef PIPE_STAGE_SKID_EN
    send(32'h41, 8'h22, n);
    #1;
    chk("t1_occ2", {62'd0, occupancy}, 64'd2);
`endif
    reset = 1'b1;
    expq.delete();
    #1;
    chk("t1_out_valid", {63'd0, out_valid}, 64'd0);
    chk("t1_out_ctrl",  {56'd0, out_ctrl}, 64'd0);
    chk("t1_occ",       {62'd0, occupancy}, 64'd0);
    chk("t1_out_data",  {32'd0, out_data}, 64'd0);
    out_ready = 1'b1;
    idle(2);
    chk("t1_in_ready0", {63'd0, in_ready}, 64'd0);
    reset = 1'b0;
    idle(1);
    send(32'h50, 8'h55, n);
    idle(2);
    chk("final_drained", 64'(expq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
